// File: rtl/execute_forwarding_history_pkg.sv
// Shared definitions for the execute-stage forwarding history: system register pointers,
// the packed history entry layout and the per-entry match helpers.
package execute_forwarding_history_pkg;

  // System register pointers used by the forwarding logic
  localparam logic [4:0] SYSREG_SPR = 5'd2;

  // History entry: valid, dest_sysreg, dest, data, spr_valid, spr_data (MSB first)
  localparam int EXFWD_ENTRY_W         = 1 + 1 + 5 + 32 + 1 + 32;
  localparam int EXFWD_SPR_DATA_LSB    = 0;
  localparam int EXFWD_SPR_VALID_BIT   = 32;
  localparam int EXFWD_DATA_LSB        = 33;
  localparam int EXFWD_DEST_LSB        = 65;
  localparam int EXFWD_DEST_SYSREG_BIT = 70;
  localparam int EXFWD_VALID_BIT       = 71;

  typedef logic [EXFWD_ENTRY_W-1:0] exfwd_vec_t;

  typedef struct packed {
    logic        valid;
    logic        dest_sysreg;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        spr_valid;
    logic [31:0] spr_data;
  } exfwd_entry_t;

  function automatic exfwd_vec_t exfwd_pack(
    input logic        valid,
    input logic        dest_sysreg,
    input logic [4:0]  dest,
    input logic [31:0] data,
    input logic        spr_valid,
    input logic [31:0] spr_data
  );
    exfwd_vec_t v;
    v = '0;
    v[EXFWD_VALID_BIT]            = valid;
    v[EXFWD_DEST_SYSREG_BIT]      = dest_sysreg;
    v[EXFWD_DEST_LSB +: 5]        = dest;
    v[EXFWD_DATA_LSB +: 32]       = data;
    v[EXFWD_SPR_VALID_BIT]        = spr_valid;
    v[EXFWD_SPR_DATA_LSB +: 32]   = spr_data;
    return v;
  endfunction

  // An SPR read hits any entry carrying an SPR update, or an explicit sysreg write to SPR
  function automatic logic exfwd_hit(
    input exfwd_entry_t e,
    input logic         src_sysreg,
    input logic [4:0]   src_pointer
  );
    logic hit;
    hit = 1'b0;
    if (e.valid) begin
      if (src_sysreg && (src_pointer == SYSREG_SPR)) begin
        hit = e.spr_valid || (e.dest_sysreg && (e.dest == SYSREG_SPR));
      end else if (src_sysreg) begin
        hit = e.dest_sysreg && (e.dest == src_pointer);
      end else begin
        hit = !e.dest_sysreg && (e.dest == src_pointer);
      end
    end
    return hit;
  endfunction

  function automatic logic [31:0] exfwd_value(
    input exfwd_entry_t e,
    input logic         src_sysreg,
    input logic [4:0]   src_pointer
  );
    logic [31:0] value;
    value = e.data;
    if (src_sysreg && (src_pointer == SYSREG_SPR) && e.spr_valid) begin
      value = e.spr_data;
    end
    return value;
  endfunction

endpackage

// File: rtl/execute_forwarding_history_match.sv
// Combinational newest-first operand match of one source channel against the live
// writeback (candidate 0) and the history entries (candidate 1 = newest).
module execute_forwarding_history_match
  import execute_forwarding_history_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [(DEPTH+1)*EXFWD_ENTRY_W-1:0] cand_flat,
  input  logic                               src_sysreg,
  input  logic                               src_imm,
  input  logic [4:0]                         src_pointer,
  input  logic [31:0]                        src_data,
  output logic [31:0]                        fwd_data
);

  exfwd_entry_t cand;

  // Walk oldest to newest so the newest hit is the last one written
  always_comb begin
    fwd_data = src_data;
    cand     = '0;
    if (!src_imm) begin
      for (int i = DEPTH; i >= 0; i--) begin
        cand = exfwd_entry_t'(cand_flat[i*EXFWD_ENTRY_W +: EXFWD_ENTRY_W]);
        if (exfwd_hit(cand, src_sysreg, src_pointer)) begin
          fwd_data = exfwd_value(cand, src_sysreg, src_pointer);
        end
      end
    end
  end

endmodule

// File: rtl/execute_forwarding_history.sv
// Execute-stage operand forwarding: DEPTH-entry history of uncommitted writebacks, NSRC
// channels fixed up newest-first, registered result with valid/busy handshake.
module execute_forwarding_history
  import execute_forwarding_history_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NSRC  = 2
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH,
  input  logic                iWB_VALID,
  input  logic [31:0]         iWB_DATA,
  input  logic [4:0]          iWB_DEST,
  input  logic                iWB_DEST_SYSREG,
  input  logic                iWB_SPR_VALID,
  input  logic [31:0]         iWB_SPR_DATA,
  output logic                oWB_FULL,
  input  logic                iCOMMIT_VALID,
  input  logic                iSRC_VALID,
  output logic                oSRC_BUSY,
  input  logic [NSRC-1:0]     iSRC_SYSREG,
  input  logic [NSRC-1:0]     iSRC_IMM,
  input  logic [NSRC*5-1:0]   iSRC_POINTER,
  input  logic [NSRC*32-1:0]  iSRC_DATA,
  input  logic [31:0]         iSRC_SPR,
  output logic                oOUT_VALID,
  input  logic                iOUT_BUSY,
  output logic [NSRC*32-1:0]  oOUT_DATA,
  output logic [31:0]         oOUT_SPR
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CAND_N = DEPTH + 1;

  exfwd_vec_t              hist_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic                    out_valid_reg, out_valid_next;
  logic [NSRC*32-1:0]      out_data_reg, out_data_next;
  logic [31:0]             out_spr_reg, out_spr_next;

  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    accept;
  exfwd_vec_t              live_entry;
  logic [CAND_N*EXFWD_ENTRY_W-1:0] cand_flat;
  logic [NSRC*32-1:0]      fwd_data;
  logic [31:0]             fwd_spr;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign oWB_FULL  = full;
  assign oSRC_BUSY = out_valid_reg && iOUT_BUSY;
  assign accept    = iSRC_VALID && !oSRC_BUSY;
  assign push      = iWB_VALID && (!full || iCOMMIT_VALID);
  assign pop       = iCOMMIT_VALID && (count_reg != '0);

  assign oOUT_VALID = out_valid_reg;
  assign oOUT_DATA  = out_data_reg;
  assign oOUT_SPR   = out_spr_reg;

  assign live_entry = exfwd_pack(iWB_VALID, iWB_DEST_SYSREG, iWB_DEST, iWB_DATA,
                                 iWB_SPR_VALID, iWB_SPR_DATA);
  assign cand_flat[0 +: EXFWD_ENTRY_W] = live_entry;

  // Candidate gi+1 is the gi-th newest entry; ages at or beyond count are stale slots
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hist
      logic [PTR_W-1:0] slot;
      exfwd_entry_t     ent;
      assign slot = wr_ptr_reg - PTR_W'(gi + 1);
      assign ent  = exfwd_entry_t'(hist_mem[slot]);
      assign cand_flat[(gi+1)*EXFWD_ENTRY_W +: EXFWD_ENTRY_W] =
        exfwd_pack(ent.valid && (CNT_W'(gi) < count_reg), ent.dest_sysreg, ent.dest,
                   ent.data, ent.spr_valid, ent.spr_data);
    end

    for (gi = 0; gi < NSRC; gi++) begin : g_chan
      execute_forwarding_history_match #(
        .DEPTH(DEPTH)
      ) u_match (
        .cand_flat   (cand_flat),
        .src_sysreg  (iSRC_SYSREG[gi]),
        .src_imm     (iSRC_IMM[gi]),
        .src_pointer (iSRC_POINTER[gi*5 +: 5]),
        .src_data    (iSRC_DATA[gi*32 +: 32]),
        .fwd_data    (fwd_data[gi*32 +: 32])
      );
    end
  endgenerate

  always_comb begin
    fwd_spr = iSRC_SPR;
    for (int i = CAND_N - 1; i >= 0; i--) begin
      if (cand_flat[i*EXFWD_ENTRY_W + EXFWD_VALID_BIT] &&
          cand_flat[i*EXFWD_ENTRY_W + EXFWD_SPR_VALID_BIT]) begin
        fwd_spr = cand_flat[i*EXFWD_ENTRY_W + EXFWD_SPR_DATA_LSB +: 32];
      end
    end
  end

  // Storage carries no reset: entry validity is derived from count
  always_ff @(posedge iCLOCK) begin
    if (push && !iFLUSH) begin
      hist_mem[wr_ptr_reg] <= live_entry;
    end
  end

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_spr_next   = out_spr_reg;
    if (iFLUSH) begin
      wr_ptr_next    = '0;
      count_next     = '0;
      out_valid_next = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      if (accept) begin
        out_valid_next = 1'b1;
        out_data_next  = fwd_data;
        out_spr_next   = fwd_spr;
      end else if (!oSRC_BUSY) begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_spr_reg   <= '0;
    end else if (iRESET_SYNC) begin
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_spr_reg   <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_spr_reg   <= out_spr_next;
    end
  end

endmodule

// File: tb/tb_execute_forwarding_history.sv
// Scoreboard bench for execute_forwarding_history: directed lookups queue expected results,
// a negedge monitor compares every consumed output.
module tb_execute_forwarding_history;
  import execute_forwarding_history_pkg::*;

  localparam int DEPTH = 4;
  localparam int NSRC  = 2;
  localparam logic [4:0] PSR = 5'd1;

  logic               iCLOCK = 1'b0;
  logic               inRESET = 1'b0;
  logic               iRESET_SYNC = 1'b0;
  logic               iFLUSH = 1'b0;
  logic               iWB_VALID = 1'b0;
  logic [31:0]        iWB_DATA = '0;
  logic [4:0]         iWB_DEST = '0;
  logic               iWB_DEST_SYSREG = 1'b0;
  logic               iWB_SPR_VALID = 1'b0;
  logic [31:0]        iWB_SPR_DATA = '0;
  logic               oWB_FULL;
  logic               iCOMMIT_VALID = 1'b0;
  logic               iSRC_VALID = 1'b0;
  logic               oSRC_BUSY;
  logic [NSRC-1:0]    iSRC_SYSREG = '0;
  logic [NSRC-1:0]    iSRC_IMM = '0;
  logic [NSRC*5-1:0]  iSRC_POINTER = '0;
  logic [NSRC*32-1:0] iSRC_DATA = '0;
  logic [31:0]        iSRC_SPR = '0;
  logic               oOUT_VALID;
  logic               iOUT_BUSY = 1'b0;
  logic [NSRC*32-1:0] oOUT_DATA;
  logic [31:0]        oOUT_SPR;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] spr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  execute_forwarding_history #(.DEPTH(DEPTH), .NSRC(NSRC)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
    .iWB_VALID(iWB_VALID), .iWB_DATA(iWB_DATA), .iWB_DEST(iWB_DEST),
    .iWB_DEST_SYSREG(iWB_DEST_SYSREG), .iWB_SPR_VALID(iWB_SPR_VALID),
    .iWB_SPR_DATA(iWB_SPR_DATA), .oWB_FULL(oWB_FULL), .iCOMMIT_VALID(iCOMMIT_VALID),
    .iSRC_VALID(iSRC_VALID), .oSRC_BUSY(oSRC_BUSY), .iSRC_SYSREG(iSRC_SYSREG),
    .iSRC_IMM(iSRC_IMM), .iSRC_POINTER(iSRC_POINTER), .iSRC_DATA(iSRC_DATA),
    .iSRC_SPR(iSRC_SPR), .oOUT_VALID(oOUT_VALID), .iOUT_BUSY(iOUT_BUSY),
    .oOUT_DATA(oOUT_DATA), .oOUT_SPR(oOUT_SPR)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
    iWB_VALID = 1'b0;
    iCOMMIT_VALID = 1'b0;
    iSRC_VALID = 1'b0;
    iFLUSH = 1'b0;
    iRESET_SYNC = 1'b0;
  endtask

  task automatic set_wb(input logic [4:0] dest, input logic sys, input logic [31:0] data,
                        input logic sprv, input logic [31:0] sprd);
    iWB_VALID = 1'b1;
    iWB_DEST = dest;
    iWB_DEST_SYSREG = sys;
    iWB_DATA = data;
    iWB_SPR_VALID = sprv;
    iWB_SPR_DATA = sprd;
  endtask

  task automatic push_gr(input logic [4:0] dest, input logic [31:0] data);
    set_wb(dest, 1'b0, data, 1'b0, 32'h0);
    tick();
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      iCOMMIT_VALID = 1'b1;
      tick();
    end
  endtask

  // Drives one lookup on both channels and queues the hand-computed result
  task automatic set_lookup(
    input logic s0, input logic i0, input logic [4:0] p0, input logic [31:0] d0,
    input logic s1, input logic i1, input logic [4:0] p1, input logic [31:0] d1,
    input logic [31:0] spr, input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] espr);
    exp_t e;
    iSRC_VALID = 1'b1;
    iSRC_SYSREG = {s1, s0};
    iSRC_IMM = {i1, i0};
    iSRC_POINTER = {p1, p0};
    iSRC_DATA = {d1, d0};
    iSRC_SPR = spr;
    e.d0 = e0;
    e.d1 = e1;
    e.spr = espr;
    exp_q.push_back(e);
  endtask

  always @(negedge iCLOCK) begin
    if (inRESET && oOUT_VALID && !iOUT_BUSY) begin
      $display("OUT d0=%h d1=%h spr=%h", oOUT_DATA[31:0], oOUT_DATA[63:32], oOUT_SPR);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=valid required=none");
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data0", oOUT_DATA[31:0], mon_e.d0);
        check("out_data1", oOUT_DATA[63:32], mon_e.d1);
        check("out_spr", oOUT_SPR, mon_e.spr);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst_full", {31'b0, oWB_FULL}, 32'h0);
    check("rst_valid", {31'b0, oOUT_VALID}, 32'h0);
    check("rst_data", oOUT_DATA[31:0], 32'h0);
    check("rst_spr", oOUT_SPR, 32'h0);
    #10;
    inRESET = 1'b1;
    @(posedge iCLOCK);
    #1;

    // Newest wins, then live writeback beats history
    push_gr(5'd5, 32'h11);
    push_gr(5'd5, 32'h22);
    set_lookup(0, 0, 5'd5, 32'h0, 0, 0, 5'd6, 32'h66, 32'h500, 32'h22, 32'h66, 32'h500);
    tick();
    set_lookup(0, 0, 5'd5, 32'h0, 0, 0, 5'd6, 32'h66, 32'h500, 32'h33, 32'h66, 32'h500);
    set_wb(5'd5, 1'b0, 32'h33, 1'b0, 32'h0);
    tick();
    commit_n(3);
    set_lookup(0, 0, 5'd5, 32'h77, 0, 0, 5'd5, 32'h78, 32'h1, 32'h77, 32'h78, 32'h1);
    tick();
    tick();

    // Asynchronous reset mid-operation with a held result
    push_gr(5'd3, 32'hA);
    push_gr(5'd3, 32'hB);
    iOUT_BUSY = 1'b1;
    set_wb(5'd3, 1'b0, 32'hC, 1'b0, 32'h0);
    set_lookup(0, 0, 5'd1, 32'h1, 0, 0, 5'd3, 32'h30, 32'h0, 32'h1, 32'hC, 32'h0);
    tick();
    check("pre_rst_valid", {31'b0, oOUT_VALID}, 32'h1);
    #2;
    inRESET = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, oOUT_VALID}, 32'h0);
    check("async_rst_data", oOUT_DATA[63:32], 32'h0);
    void'(exp_q.pop_back());
    inRESET = 1'b1;
    iOUT_BUSY = 1'b0;
    set_lookup(0, 0, 5'd3, 32'h3333, 0, 0, 5'd3, 32'h4444, 32'h2, 32'h3333, 32'h4444, 32'h2);
    tick();
    tick();

    // Full, dropped push, push+commit wrap
    push_gr(5'd1, 32'h101);
    push_gr(5'd2, 32'h102);
    push_gr(5'd3, 32'h103);
    push_gr(5'd4, 32'h104);
    check("full_after_4", {31'b0, oWB_FULL}, 32'h1);
    push_gr(5'd5, 32'h105);
    check("full_after_drop", {31'b0, oWB_FULL}, 32'h1);
    set_lookup(0, 0, 5'd5, 32'h5, 0, 0, 5'd1, 32'h0, 32'h0, 32'h5, 32'h101, 32'h0);
    tick();
    for (int j = 0; j < 10; j++) begin
      logic [4:0] popped;
      logic [4:0] fresh;
      popped = (j < 4) ? 5'(j + 1) : 5'(8 + j - 4);
      fresh = 5'(8 + j);
      set_wb(fresh, 1'b0, 32'h200 + 32'(j), 1'b0, 32'h0);
      iCOMMIT_VALID = 1'b1;
      tick();
      check("wrap_full", {31'b0, oWB_FULL}, 32'h1);
      set_lookup(0, 0, popped, 32'hDEAD, 0, 0, fresh, 32'h0, 32'h0,
                 32'hDEAD, 32'h200 + 32'(j), 32'h0);
      tick();
    end
    commit_n(4);
    check("drained_full", {31'b0, oWB_FULL}, 32'h0);

    // Sysreg write with SPR update
    set_wb(PSR, 1'b1, 32'hA5, 1'b1, 32'h1000);
    tick();
    set_lookup(1, 0, PSR, 32'h0, 0, 0, 5'd0, 32'h1234, 32'h9, 32'hA5, 32'h1234, 32'h1000);
    tick();
    set_lookup(1, 0, SYSREG_SPR, 32'h7, 0, 0, PSR, 32'h42, 32'h9, 32'h1000, 32'h42, 32'h1000);
    tick();
    commit_n(1);

    // Immediate bypass and consumer stall
    push_gr(5'd2, 32'h222);
    iOUT_BUSY = 1'b1;
    set_lookup(0, 1, 5'd2, 32'h99, 0, 0, 5'd2, 32'h0, 32'h5, 32'h99, 32'h222, 32'h5);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("stall_busy", {31'b0, oSRC_BUSY}, 32'h1);
      iSRC_VALID = 1'b1;
      iSRC_IMM = 2'b00;
      iSRC_DATA = {32'hFFFF_0001, 32'hFFFF_0002};
      tick();
      check("stall_valid", {31'b0, oOUT_VALID}, 32'h1);
      check("stall_d0", oOUT_DATA[31:0], 32'h99);
      check("stall_d1", oOUT_DATA[63:32], 32'h222);
      check("stall_spr", oOUT_SPR, 32'h5);
    end
    iOUT_BUSY = 1'b0;
    tick();
    tick();
    check("post_stall_valid", {31'b0, oOUT_VALID}, 32'h0);
    commit_n(1);

    // Flush with full history, pending result and simultaneous writeback
    push_gr(5'd1, 32'h301);
    push_gr(5'd2, 32'h302);
    push_gr(5'd3, 32'h303);
    push_gr(5'd4, 32'h304);
    iOUT_BUSY = 1'b1;
    set_lookup(0, 0, 5'd4, 32'h0, 0, 0, 5'd1, 32'h0, 32'h0, 32'h304, 32'h301, 32'h0);
    tick();
    check("preflush_full", {31'b0, oWB_FULL}, 32'h1);
    check("preflush_valid", {31'b0, oOUT_VALID}, 32'h1);
    iFLUSH = 1'b1;
    set_wb(5'd7, 1'b0, 32'h777, 1'b0, 32'h0);
    iCOMMIT_VALID = 1'b1;
    tick();
    void'(exp_q.pop_back());
    check("flush_full", {31'b0, oWB_FULL}, 32'h0);
    check("flush_valid", {31'b0, oOUT_VALID}, 32'h0);
    iOUT_BUSY = 1'b0;
    set_lookup(0, 0, 5'd7, 32'h70, 0, 0, 5'd1, 32'h10, 32'h0, 32'h70, 32'h10, 32'h0);
    tick();
    tick();

    // Synchronous reset
    push_gr(5'd9, 32'h999);
    iRESET_SYNC = 1'b1;
    tick();
    set_lookup(0, 0, 5'd9, 32'h9, 0, 0, 5'd9, 32'h8, 32'h3, 32'h9, 32'h8, 32'h3);
    tick();
    tick();
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
